// File: rtl/hdmi_deserializer_1_to_10.sv
// TMDS 1:10 deserializer: packs DDIO_IN bit pairs into 10-bit characters and
// recovers word alignment by hunting for control tokens at one of 10 bit offsets.
module hdmi_deserializer_1_to_10 #(
  parameter int LOCK_TOKENS = 8,
  parameter int LOSS_WORDS  = 4096
) (
  input  logic       serial_clk_5x,
  input  logic       sys_rst_n,
  input  logic       datain_rise,
  input  logic       datain_fall,
  output logic [9:0] paralell_data,
  output logic       data_valid,
  output logic       locked,
  output logic [3:0] bit_offset
);
  localparam int TW = $clog2(LOCK_TOKENS + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);
  localparam logic [TW-1:0] TOK_TGT  = TW'(LOCK_TOKENS);
  localparam logic [TW-1:0] TOK_ONE  = TW'(1);
  localparam logic [LW-1:0] LOSS_TGT = LW'(LOSS_WORDS);
  localparam logic [LW-1:0] LOSS_ONE = LW'(1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [19:0]     shreg;
  logic [2:0]      phase;
  logic [TW-1:0]   tok_cnt, tok_cnt_nxt;
  logic [LW-1:0]   loss_cnt, loss_cnt_nxt;
  logic [3:0]      off_nxt, first_k;
  logic [9:0][9:0] slice;
  logic [9:0]      is_tok;
  logic [9:0]      cur_slice;
  logic            any_tok, cur_tok, strobe;

  // phase 0 follows the edge that absorbed the fifth pair of a word window
  assign strobe  = (phase == 3'd0);
  assign any_tok = |is_tok;

  for (genvar k = 0; k < 10; k++) begin : g_slice
    assign slice[k]  = shreg[k +: 10];
    assign is_tok[k] = (slice[k] == 10'h354) || (slice[k] == 10'h0AB) ||
                       (slice[k] == 10'h154) || (slice[k] == 10'h2AB);
  end

  // downward scan so the lowest token offset wins
  always_comb begin
    first_k   = '0;
    cur_slice = '0;
    cur_tok   = 1'b0;
    for (int k = 9; k >= 0; k--)
      if (is_tok[k]) first_k = 4'(k);
    for (int k = 0; k < 10; k++)
      if (bit_offset == 4'(k)) begin
        cur_slice = slice[k];
        cur_tok   = is_tok[k];
      end
  end

  always_comb begin
    state_nxt    = state;
    tok_cnt_nxt  = tok_cnt;
    loss_cnt_nxt = loss_cnt;
    off_nxt      = bit_offset;
    case (state)
      SEARCH: if (any_tok) begin
        off_nxt = first_k;
        if (LOCK_TOKENS == 1) begin
          state_nxt    = LOCKED;
          tok_cnt_nxt  = '0;
          loss_cnt_nxt = '0;
        end else begin
          state_nxt   = VERIFY;
          tok_cnt_nxt = TOK_ONE;
        end
      end
      VERIFY: begin
        if (cur_tok) begin
          if (tok_cnt + TOK_ONE == TOK_TGT) begin
            state_nxt    = LOCKED;
            tok_cnt_nxt  = '0;
            loss_cnt_nxt = '0;
          end else begin
            tok_cnt_nxt = tok_cnt + TOK_ONE;
          end
        end else if (any_tok) begin
          // token at a different offset: drop the candidate, rescan next word
          state_nxt   = SEARCH;
          tok_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (cur_tok) begin
          loss_cnt_nxt = '0;
        end else if (loss_cnt + LOSS_ONE == LOSS_TGT) begin
          state_nxt    = SEARCH;
          tok_cnt_nxt  = '0;
          loss_cnt_nxt = '0;
        end else begin
          loss_cnt_nxt = loss_cnt + LOSS_ONE;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge serial_clk_5x or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shreg         <= '0;
      phase         <= '0;
      state         <= SEARCH;
      tok_cnt       <= '0;
      loss_cnt      <= '0;
      bit_offset    <= '0;
      paralell_data <= '0;
      data_valid    <= 1'b0;
      locked        <= 1'b0;
    end else begin
      shreg      <= {datain_fall, datain_rise, shreg[19:2]};
      phase      <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
      data_valid <= strobe && (state_nxt == LOCKED);
      if (strobe) begin
        state         <= state_nxt;
        tok_cnt       <= tok_cnt_nxt;
        loss_cnt      <= loss_cnt_nxt;
        bit_offset    <= off_nxt;
        paralell_data <= cur_slice;
        locked        <= (state_nxt == LOCKED);
      end
    end
  end
endmodule
